// File: rtl/hans_isa_pkg.sv
// Hans core ISA definitions: opcodes, format fields, decode bundle and the
// purely combinational instruction decoder shared by the decode stage.
package hans_isa_pkg;

  localparam logic [5:0] OP_LOAD   = 6'b111000;
  localparam logic [5:0] OP_LOADS  = 6'b111001;
  localparam logic [5:0] OP_STORE  = 6'b111010;
  localparam logic [5:0] OP_STORES = 6'b111011;
  localparam logic [5:0] OP_JREG   = 6'b111100;
  localparam logic [5:0] OP_BEZ    = 6'b111101;
  localparam logic [5:0] OP_BNEZ   = 6'b111110;
  localparam logic [5:0] OP_JAL    = 6'b111111;
  localparam logic [5:0] OP_JMP    = 6'b010000;
  localparam logic [5:0] OP_ADDIS  = 6'b110000;

  localparam logic [1:0] FMT_REGISTER = 2'b00;
  localparam logic [1:0] FMT_SPRUNG   = 2'b01;
  localparam logic [1:0] KAT_FLOAT    = 2'b10;

  typedef enum logic {BEREIT, GESPERRT} steuerZustandT;

  // Register indices are 6 bit: bit 5 selects the float bank.
  typedef struct packed {
    logic [5:0]  quell1;
    logic [5:0]  quell2;
    logic [5:0]  ziel;
    logic [31:0] iDaten;
    logic        immAktiv;
    logic [5:0]  funktion;
    logic        jal;
    logic        relativ;
    logic        absolut;
    logic        load;
    logic        store;
    logic        unbedingt;
    logic        bedingt;
    logic        bedingung;
  } dekodBuendelT;

  function automatic dekodBuendelT dekodiere(input logic [31:0] wort);
    dekodBuendelT b;
    logic [5:0] opc;
    logic [4:0] z;
    logic regF, sprF, immF, floatReg;
    opc      = wort[31:26];
    z        = wort[25:21];
    regF     = (wort[31:30] == FMT_REGISTER);
    sprF     = (wort[31:30] == FMT_SPRUNG);
    immF     = wort[31];
    floatReg = regF && (wort[5:4] == KAT_FLOAT);
    b        = '0;

    b.quell1 = {floatReg, wort[20:16]};
    if (opc == OP_STORE)       b.quell2 = {1'b0, z};
    else if (opc == OP_STORES) b.quell2 = {1'b1, z};
    else                       b.quell2 = {floatReg, wort[15:11]};

    // Float ops with float op >= 8 write an integer register (compares, moves).
    if (opc == OP_LOADS || opc == OP_STORES || (floatReg && !wort[3])) b.ziel = {1'b1, z};
    else if (regF || immF)                                            b.ziel = {1'b0, z};

    if (sprF)                 b.iDaten = {6'b0, wort[25:0]};
    else if (opc == OP_ADDIS) b.iDaten = {wort[15:0], 16'h0000};
    else if (immF)            b.iDaten = {{16{wort[15]}}, wort[15:0]};

    // IDaten carries an operand for every non-register format.
    b.immAktiv = sprF | immF;

    if (regF)                                             b.funktion = wort[5:0];
    else if (opc == OP_ADDIS || sprF || opc[5:3] == 3'b111) b.funktion = '0;
    else                                                  b.funktion = {1'b0, opc[4:0]};

    b.jal       = (opc == OP_JAL);
    b.relativ   = (opc == OP_JAL) || (opc == OP_JMP) || (opc == OP_BEZ) || (opc == OP_BNEZ);
    b.absolut   = (opc == OP_JREG);
    b.load      = (opc == OP_LOAD) || (opc == OP_LOADS);
    b.store     = (opc == OP_STORE) || (opc == OP_STORES);
    b.unbedingt = (opc == OP_JREG) || (opc == OP_JAL) || (opc == OP_JMP);
    b.bedingt   = (opc == OP_BEZ) || (opc == OP_BNEZ);
    b.bedingung = (opc == OP_BEZ);
    return b;
  endfunction

  function automatic logic istSprung(input dekodBuendelT b);
    return b.unbedingt | b.bedingt;
  endfunction

endpackage

// File: rtl/instruktions_dekodier_puffer_if.sv
// Fetch-side and issue-side handshakes of the decode stage.
interface instruktions_dekodier_puffer_if #(
  parameter int ADRESS_BREITE = 32,
  parameter int REG_BREITE    = 6
);
  logic                     EingangGueltig;
  logic                     EingangBereit;
  logic [31:0]              Instruktion;
  logic [ADRESS_BREITE-1:0] BefehlsAdresse;
  logic                     AusgangGueltig;
  logic                     AusgangBereit;
  logic                     Leeren;
  logic                     Fortsetzen;
  logic [REG_BREITE-1:0]    QuellRegister1;
  logic [REG_BREITE-1:0]    QuellRegister2;
  logic [REG_BREITE-1:0]    ZielRegister;
  logic [31:0]              IDaten;
  logic                     ImmediateAktiv;
  logic [5:0]               FunktionsCode;
  logic                     JALBefehl;
  logic                     RelativerSprung;
  logic                     AbsoluterSprung;
  logic                     LoadBefehl;
  logic                     StoreBefehl;
  logic                     UnbedingterSprungBefehl;
  logic                     BedingterSprungBefehl;
  logic                     Sprungbedingung;
  logic [ADRESS_BREITE-1:0] AusgangAdresse;

  // Decode stage side.
  modport slave (
    input  EingangGueltig, Instruktion, BefehlsAdresse, AusgangBereit, Leeren, Fortsetzen,
    output EingangBereit, AusgangGueltig, QuellRegister1, QuellRegister2, ZielRegister,
           IDaten, ImmediateAktiv, FunktionsCode, JALBefehl, RelativerSprung,
           AbsoluterSprung, LoadBefehl, StoreBefehl, UnbedingterSprungBefehl,
           BedingterSprungBefehl, Sprungbedingung, AusgangAdresse
  );

  // Fetch / execute side.
  modport master (
    output EingangGueltig, Instruktion, BefehlsAdresse, AusgangBereit, Leeren, Fortsetzen,
    input  EingangBereit, AusgangGueltig, QuellRegister1, QuellRegister2, ZielRegister,
           IDaten, ImmediateAktiv, FunktionsCode, JALBefehl, RelativerSprung,
           AbsoluterSprung, LoadBefehl, StoreBefehl, UnbedingterSprungBefehl,
           BedingterSprungBefehl, Sprungbedingung, AusgangAdresse
  );
endinterface

// File: rtl/befehls_fifo.sv
// Instruction FIFO: power-of-two depth, wrapping pointers, occupancy count,
// synchronous flush. Callers never write when full or read when empty.
module befehls_fifo #(
  parameter int TIEFE  = 4,
  parameter int BREITE = 64
) (
  input  logic                  Takt,
  input  logic                  Reset,
  input  logic                  Leeren,
  input  logic                  Schreiben,
  input  logic                  Lesen,
  input  logic [BREITE-1:0]     SchreibDaten,
  output logic [BREITE-1:0]     LeseDaten,
  output logic [$clog2(TIEFE):0] Anzahl
);
  localparam int ZB = $clog2(TIEFE);
  localparam int AB = ZB + 1;

  logic [BREITE-1:0] speicher [TIEFE];
  logic [ZB-1:0]     schreibZeiger;
  logic [ZB-1:0]     leseZeiger;

  assign LeseDaten = speicher[leseZeiger];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at TIEFE.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) begin
      schreibZeiger <= '0;
      leseZeiger    <= '0;
      Anzahl        <= '0;
    end else if (Leeren) begin
      schreibZeiger <= '0;
      leseZeiger    <= '0;
      Anzahl        <= '0;
    end else begin
      if (Schreiben) schreibZeiger <= schreibZeiger + ZB'(1);
      if (Lesen)     leseZeiger    <= leseZeiger + ZB'(1);
      case ({Schreiben, Lesen})
        2'b10:   Anzahl <= Anzahl + AB'(1);
        2'b01:   Anzahl <= Anzahl - AB'(1);
        default: Anzahl <= Anzahl;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge Takt) begin
    if (Schreiben) speicher[schreibZeiger] <= SchreibDaten;
  end

endmodule

// File: rtl/instruktions_dekodier_puffer.sv
// Hans decode stage: instruction FIFO, issue FSM with optional post-jump
// lock, and the registered decode bundle presented downstream.
module instruktions_dekodier_puffer
  import hans_isa_pkg::*;
#(
  parameter int TIEFE         = 4,
  parameter int ADRESS_BREITE = 32,
  parameter int REG_BREITE    = 6,
  parameter bit SPRUNG_SPERRE = 1'b1
) (
  input logic Takt,
  input logic Reset,
  instruktions_dekodier_puffer_if.slave bus
);
  localparam int EINTRAG_BREITE = 32 + ADRESS_BREITE;
  localparam int ANZ_BREITE     = $clog2(TIEFE) + 1;

  logic [ANZ_BREITE-1:0]     anzahl;
  logic [EINTRAG_BREITE-1:0] kopfEintrag;
  logic                      fifoVoll, fifoLeer, schreiben, ausgeben;
  dekodBuendelT              kopfBuendel, ausgabeBuendel;
  logic [ADRESS_BREITE-1:0]  ausgabeAdresse;
  logic                      ausgabeGueltig;
  steuerZustandT             zustand, folgeZustand;

  assign fifoVoll    = (anzahl == ANZ_BREITE'(TIEFE));
  assign fifoLeer    = (anzahl == '0);
  // A flush drops whatever is offered in the same cycle.
  assign schreiben   = bus.EingangGueltig && !fifoVoll && !bus.Leeren;
  assign kopfBuendel = dekodiere(kopfEintrag[EINTRAG_BREITE-1 -: 32]);

  befehls_fifo #(
    .TIEFE  (TIEFE),
    .BREITE (EINTRAG_BREITE)
  ) u_fifo (
    .Takt         (Takt),
    .Reset        (Reset),
    .Leeren       (bus.Leeren),
    .Schreiben    (schreiben),
    .Lesen        (ausgeben),
    .SchreibDaten ({bus.Instruktion, bus.BefehlsAdresse}),
    .LeseDaten    (kopfEintrag),
    .Anzahl       (anzahl)
  );

  // Issue FSM state register.
  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) zustand <= BEREIT;
    else       zustand <= folgeZustand;
  end

  // Next state: lock after an issued jump, release on Fortsetzen, flush wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    folgeZustand = zustand;
    if (bus.Leeren) begin
      folgeZustand = BEREIT;
    end else begin
      case (zustand)
        BEREIT:   if (ausgeben && SPRUNG_SPERRE && istSprung(kopfBuendel)) folgeZustand = GESPERRT;
        GESPERRT: if (bus.Fortsetzen) folgeZustand = BEREIT;
        default:  folgeZustand = BEREIT;
      endcase
    end
  end

  // Issue when unlocked, a word is queued and the output slot is free or draining.
  always_comb begin
    ausgeben = 1'b0;
    if (zustand == BEREIT && !fifoLeer && !bus.Leeren && (!ausgabeGueltig || bus.AusgangBereit))
      ausgeben = 1'b1;
  end

  // Decode output register; holds while downstream stalls.
  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) begin
      ausgabeGueltig <= 1'b0;
      ausgabeBuendel <= '0;
      ausgabeAdresse <= '0;
    end else if (bus.Leeren) begin
      ausgabeGueltig <= 1'b0;
    end else if (ausgeben) begin
      ausgabeGueltig <= 1'b1;
      ausgabeBuendel <= kopfBuendel;
      ausgabeAdresse <= kopfEintrag[ADRESS_BREITE-1:0];
    end else if (bus.AusgangBereit) begin
      ausgabeGueltig <= 1'b0;
    end
  end

  assign bus.EingangBereit           = !fifoVoll;
  assign bus.AusgangGueltig          = ausgabeGueltig;
  assign bus.QuellRegister1          = REG_BREITE'(ausgabeBuendel.quell1);
  assign bus.QuellRegister2          = REG_BREITE'(ausgabeBuendel.quell2);
  assign bus.ZielRegister            = REG_BREITE'(ausgabeBuendel.ziel);
  assign bus.IDaten                  = ausgabeBuendel.iDaten;
  assign bus.ImmediateAktiv          = ausgabeBuendel.immAktiv;
  assign bus.FunktionsCode           = ausgabeBuendel.funktion;
  assign bus.JALBefehl               = ausgabeBuendel.jal;
  assign bus.RelativerSprung         = ausgabeBuendel.relativ;
  assign bus.AbsoluterSprung         = ausgabeBuendel.absolut;
  assign bus.LoadBefehl              = ausgabeBuendel.load;
  assign bus.StoreBefehl             = ausgabeBuendel.store;
  assign bus.UnbedingterSprungBefehl = ausgabeBuendel.unbedingt;
  assign bus.BedingterSprungBefehl   = ausgabeBuendel.bedingt;
  assign bus.Sprungbedingung         = ausgabeBuendel.bedingung;
  assign bus.AusgangAdresse          = ausgabeAdresse;

endmodule

// File: tb/tb_instruktions_dekodier_puffer.sv
// Self-checking bench for the Hans decode stage: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_instruktions_dekodier_puffer;

  localparam int TIEFE  = 4;
  localparam bit SPERRE = 1'b1;

  logic Takt;
  logic Reset;

  instruktions_dekodier_puffer_if #(.ADRESS_BREITE(32), .REG_BREITE(6)) bus ();

  instruktions_dekodier_puffer #(
    .TIEFE         (TIEFE),
    .ADRESS_BREITE (32),
    .REG_BREITE    (6),
    .SPRUNG_SPERRE (SPERRE)
  ) dut (
    .Takt  (Takt),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Takt = 1'b0;
  always #5 Takt = ~Takt;

  int nVektoren = 0;
  int nFehler   = 0;

  task automatic check(input string name, input logic [63:0] ist, input logic [63:0] soll);
    nVektoren++;
    if (ist !== soll) begin
      nFehler++;
      $display("FAIL %s: ist=%h soll=%h t=%0t", name, ist, soll, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  q1, q2, z;
    logic [31:0] imm;
    logic        immA;
    logic [5:0]  fc;
    logic [7:0]  flags; // jal rel abs load store unbed bed cond
  } erwartT;

  function automatic erwartT modellDekodierung(input logic [31:0] w);
    erwartT e;
    int op, zz, q1, q2;
    bit istReg, istSprungFmt, istImm, fl;
    bit jal, rel, abs_, ld, st, unb, bed, cond;
    op = int'(w[31:26]); zz = int'(w[25:21]); q1 = int'(w[20:16]); q2 = int'(w[15:11]);
    istReg = (w[31:30] == 2'd0);
    istSprungFmt = (w[31:30] == 2'd1);
    istImm = w[31];
    fl = istReg && (w[5:4] == 2'b10);
    e = '0;
    e.q1 = 6'((fl ? 32 : 0) + q1);
    if (op == 'h3A)      e.q2 = 6'(zz);
    else if (op == 'h3B) e.q2 = 6'(32 + zz);
    else                 e.q2 = 6'((fl ? 32 : 0) + q2);
    if (op == 'h39 || op == 'h3B || (fl && int'(w[3:0]) < 8)) e.z = 6'(32 + zz);
    else if (istReg || istImm) e.z = 6'(zz);
    else e.z = 6'd0;
    if (istSprungFmt)    e.imm = w & 32'h03FF_FFFF;
    else if (op == 'h30) e.imm = 32'(w[15:0]) << 16;
    else if (istImm)     e.imm = 32'($signed(w[15:0]));
    else                 e.imm = 32'd0;
    e.immA = !istReg;
    if (istReg) e.fc = w[5:0];
    else if (op == 'h30 || istSprungFmt || op >= 'h38) e.fc = 6'd0;
    else e.fc = 6'(op % 32);
    jal  = (op == 'h3F);
    rel  = op inside {'h3F, 'h10, 'h3D, 'h3E};
    abs_ = (op == 'h3C);
    ld   = op inside {'h38, 'h39};
    st   = op inside {'h3A, 'h3B};
    unb  = op inside {'h3C, 'h3F, 'h10};
    bed  = op inside {'h3D, 'h3E};
    cond = (op == 'h3D);
    e.flags = {jal, rel, abs_, ld, st, unb, bed, cond};
    return e;
  endfunction

  logic [63:0] mQ [$];
  bit          mValid, mLocked;
  logic [31:0] mInstr, mAddr;

  task automatic modellSchritt();
    bit voll, annehmen, ausgeben, warGesperrt;
    logic [63:0] kopf;
    erwartT e;
    if (bus.Leeren) begin
      mQ.delete();
      mValid  = 1'b0;
      mLocked = 1'b0;
    end else begin
      voll        = (mQ.size() == TIEFE);
      annehmen    = bus.EingangGueltig && !voll;
      ausgeben    = !mLocked && (mQ.size() != 0) && (!mValid || bus.AusgangBereit);
      warGesperrt = mLocked;
      if (ausgeben) begin
        kopf   = mQ.pop_front();
        mValid = 1'b1;
        mInstr = kopf[63:32];
        mAddr  = kopf[31:0];
      end else if (bus.AusgangBereit) begin
        mValid = 1'b0;
      end
      e = modellDekodierung(mInstr);
      if (warGesperrt && bus.Fortsetzen) mLocked = 1'b0;
      else if (ausgeben && SPERRE && (e.flags[2] || e.flags[1])) mLocked = 1'b1;
      if (annehmen) mQ.push_back({bus.Instruktion, bus.BefehlsAdresse});
    end
  endtask

  always @(posedge Takt or posedge Reset) begin
    if (Reset) begin
      mQ.delete();
      mValid = 1'b0; mLocked = 1'b0; mInstr = '0; mAddr = '0;
    end else begin
      modellSchritt();
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge Takt) begin
    erwartT e;
    if (!Reset) begin
      check("EingangBereit", bus.EingangBereit, mQ.size() < TIEFE);
      check("AusgangGueltig", bus.AusgangGueltig, mValid);
      if (mValid) begin
        e = modellDekodierung(mInstr);
        check("QuellRegister1", bus.QuellRegister1, e.q1);
        check("QuellRegister2", bus.QuellRegister2, e.q2);
        check("ZielRegister", bus.ZielRegister, e.z);
        check("IDaten", bus.IDaten, e.imm);
        check("ImmediateAktiv", bus.ImmediateAktiv, e.immA);
        check("FunktionsCode", bus.FunktionsCode, e.fc);
        check("Flags", {bus.JALBefehl, bus.RelativerSprung, bus.AbsoluterSprung, bus.LoadBefehl,
                        bus.StoreBefehl, bus.UnbedingterSprungBefehl, bus.BedingterSprungBefehl,
                        bus.Sprungbedingung}, e.flags);
        check("AusgangAdresse", bus.AusgangAdresse, mAddr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge Takt);
    #1;
  endtask

  task automatic setze(input bit g, input logic [31:0] w, input logic [31:0] a,
                       input bit ab, input bit le, input bit fo);
    bus.EingangGueltig  = g;
    bus.Instruktion     = w;
    bus.BefehlsAdresse  = a;
    bus.AusgangBereit   = ab;
    bus.Leeren          = le;
    bus.Fortsetzen      = fo;
  endtask

  // Offer one word into an idle stage; returns with the decoded word valid.
  task automatic einzelWort(input logic [31:0] w, input logic [31:0] a);
    setze(1, w, a, 1, 0, 0);
    step();
    setze(0, 32'h0, 32'h0, 1, 0, 0);
    check("latenz_noch_nicht_gueltig", bus.AusgangGueltig, 0);
    step();
  endtask

  function automatic logic [31:0] zufallsWort();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: w[31:26] = 6'h38 + 6'($urandom_range(0, 7));
      1: w[31:26] = 6'h10;
      2: w[31:26] = 6'h30;
      3: begin w[31:30] = 2'b00; w[5:4] = 2'b10; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int idx;
    bit ok;
    Reset = 1'b1;
    setze(0, 32'h0, 32'h0, 0, 0, 0);
    step(3);
    Reset = 1'b0;
    step();

    // Reset state
    check("reset_EingangBereit", bus.EingangBereit, 1);
    check("reset_AusgangGueltig", bus.AusgangGueltig, 0);
    check("reset_IDaten", bus.IDaten, 0);
    check("reset_Register", {bus.QuellRegister1, bus.QuellRegister2, bus.ZielRegister}, 0);
    check("reset_FunktionsCode", bus.FunktionsCode, 0);
    check("reset_Flags", {bus.JALBefehl, bus.RelativerSprung, bus.AbsoluterSprung, bus.LoadBefehl,
                          bus.StoreBefehl, bus.UnbedingterSprungBefehl, bus.BedingterSprungBefehl,
                          bus.Sprungbedingung, bus.ImmediateAktiv}, 0);
    check("reset_AusgangAdresse", bus.AusgangAdresse, 0);

    // Addis
    einzelWort(32'hC022_1234, 32'h100);
    check("addis_gueltig", bus.AusgangGueltig, 1);
    check("addis_Ziel", bus.ZielRegister, 6'd1);
    check("addis_Q1", bus.QuellRegister1, 6'd2);
    check("addis_IDaten", bus.IDaten, 32'h1234_0000);
    check("addis_FC", bus.FunktionsCode, 6'd0);
    check("addis_Adresse", bus.AusgangAdresse, 32'h100);
    step();

    // StoreS
    einzelWort(32'hEC43_0008, 32'h104);
    check("stores_Q2", bus.QuellRegister2, 6'h22);
    check("stores_Ziel", bus.ZielRegister, 6'h22);
    check("stores_Store", bus.StoreBefehl, 1);
    check("stores_IDaten", bus.IDaten, 32'd8);
    step();

    // Float register ops: float op 3 writes float bank, float op 9 does not
    einzelWort(32'h0064_2823, 32'h108);
    check("float3_Q1", bus.QuellRegister1, 6'h24);
    check("float3_Q2", bus.QuellRegister2, 6'h25);
    check("float3_Ziel", bus.ZielRegister, 6'h23);
    check("float3_FC", bus.FunktionsCode, 6'h23);
    step();
    einzelWort(32'h0064_2829, 32'h10C);
    check("float9_Ziel", bus.ZielRegister, 6'h03);
    check("float9_Q1", bus.QuellRegister1, 6'h24);
    step();

    // Fill with a stalled consumer: TIEFE+1 accepts, then back-pressure
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      setze(1, 32'hC400_0000 | 32'(idx), 32'h2000 + 32'(4 * idx), 0, 0, 0);
      ok = bus.EingangBereit;
      step();
      if (ok) idx++;
    end
    check("fuell_annahmen", 64'(idx), TIEFE + 1);
    check("fuell_EingangBereit", bus.EingangBereit, 0);
    check("fuell_erste_Adresse", bus.AusgangAdresse, 32'h2000);
    setze(0, 32'h0, 32'h0, 0, 0, 0);
    step(2);
    check("fuell_stabil", bus.AusgangAdresse, 32'h2000);
    setze(0, 32'h0, 32'h0, 1, 0, 0);
    step();
    check("drain_zweite_Adresse", bus.AusgangAdresse, 32'h2004);
    step(5);
    check("drain_leer", bus.AusgangGueltig, 0);

    // Jump lock: JAL then Load
    setze(1, 32'hFC00_0010, 32'h3000, 1, 0, 0);
    step();
    setze(1, 32'hE0A4_0004, 32'h3004, 1, 0, 0);
    step();
    setze(0, 32'h0, 32'h0, 1, 0, 0);
    check("jal_gueltig", bus.AusgangGueltig, 1);
    check("jal_JAL", bus.JALBefehl, 1);
    check("jal_IDaten", bus.IDaten, 32'h10);
    step(3);
    check("sperre_haelt_load", bus.AusgangGueltig, 0);
    setze(0, 32'h0, 32'h0, 1, 0, 1);
    step();
    setze(0, 32'h0, 32'h0, 1, 0, 0);
    check("fortsetzen_noch_kein_load", bus.AusgangGueltig, 0);
    step();
    check("load_gueltig", bus.AusgangGueltig, 1);
    check("load_Load", bus.LoadBefehl, 1);
    check("load_Ziel", bus.ZielRegister, 6'd5);
    check("load_Adresse", bus.AusgangAdresse, 32'h3004);
    step();

    // Flush with three queued entries and a word offered in the same cycle
    for (int c = 0; c < 4; c++) begin
      setze(1, 32'hC400_0100 | 32'(c), 32'h4000 + 32'(4 * c), 0, 0, 0);
      step();
    end
    setze(1, 32'hC400_0FFF, 32'h4FFF, 0, 1, 0);
    step();
    check("leeren_AusgangGueltig", bus.AusgangGueltig, 0);
    check("leeren_EingangBereit", bus.EingangBereit, 1);
    setze(0, 32'h0, 32'h0, 1, 0, 0);
    step(3);
    check("leeren_wort_verworfen", bus.AusgangGueltig, 0);

    // Randomized traffic with one asynchronous reset mid-run
    for (int i = 0; i < 1500; i++) begin
      setze(($urandom_range(0, 9) < 7), zufallsWort(), $urandom(),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) == 0));
      if (i == 700) begin
        #2;
        Reset = 1'b1;
        #1;
        check("reset_sofort_AusgangGueltig", bus.AusgangGueltig, 0);
        check("reset_sofort_EingangBereit", bus.EingangBereit, 1);
        check("reset_sofort_IDaten", bus.IDaten, 0);
      end
      step();
      if (i == 700) Reset = 1'b0;
    end

    // Drain
    setze(0, 32'h0, 32'h0, 1, 0, 1);
    step(12);
    check("ende_leer", bus.AusgangGueltig, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVektoren, nFehler);
    $finish;
  end

endmodule
